// File: rtl/crc15_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// crc15_pkg : controller state encoding, widths, shift-count helper
// Rev 1.0
// ------------------------------------------------------------------
package crc15_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int REM_W = 15;
  localparam int CNT_W = 11;

  function automatic int total_shifts(input int n, input int r);
    return n + r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc15_sys.sv
`default_nettype none
// ------------------------------------------------------------------
// crc15_sys : remainder shift register plus its sequencer.
// Rev 1.0
// ------------------------------------------------------------------
module crc15_rem_reg #(
  parameter int N     = 64,
  parameter int CNT_W = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        shift,
  input  logic [N-1:0]                data_in,
  output logic [CNT_W-1:0]            count,
  output logic [crc15_pkg::REM_W-1:0] data_out
);
  logic [CNT_W-1:0]            count_q, count_d;
  logic [crc15_pkg::REM_W-1:0] rem_q, rem_d;
  logic [N-1:0]                aligned;

  // Data is consumed MSB-first; once count reaches N the shift yields zero.
  always_comb begin
    aligned = data_in << count_q;
    count_d = count_q;
    rem_d   = rem_q;
    if (shift) begin
      count_d = count_q + 1'b1;
      rem_d   = {aligned[N-1] ^ rem_q[0], rem_q[crc15_pkg::REM_W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      rem_q   <= '0;
    end else begin
      count_q <= count_d;
      rem_q   <= rem_d;
    end
  end

  assign count    = count_q;
  assign data_out = rem_q;
endmodule

module crc15_sys #(
  parameter int N     = 64,
  parameter int R     = 15,
  parameter int CNT_W = crc15_pkg::CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N-1:0]                in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [crc15_pkg::REM_W-1:0] out_rem,
  output logic                        out_nz,
  output logic                        out_cnt_err
);
  logic                        dp_rst;
  logic                        dp_shift;
  logic [N-1:0]                dp_data;
  logic [CNT_W-1:0]            dp_count;
  logic [crc15_pkg::REM_W-1:0] dp_rem;

  crc15_seq_ctrl #(.N(N), .R(R), .CNT_W(CNT_W)) u_ctrl (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_rem(out_rem),
    .out_nz(out_nz), .out_cnt_err(out_cnt_err),
    .dp_rst(dp_rst), .dp_shift(dp_shift), .dp_data(dp_data),
    .dp_count(dp_count), .dp_rem(dp_rem)
  );

  crc15_rem_reg #(.N(N), .CNT_W(CNT_W)) u_rem (
    .clk(clk), .rst(dp_rst), .shift(dp_shift), .data_in(dp_data),
    .count(dp_count), .data_out(dp_rem)
  );
endmodule
`default_nettype wire

// File: rtl/crc15_seq_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// crc15_seq_ctrl : accepts a word, clears and steps the remainder
// register N+R times, then presents the result.  Rev 1.0
// ------------------------------------------------------------------
module crc15_seq_ctrl #(
  parameter int N     = 64,
  parameter int R     = 15,
  parameter int CNT_W = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N-1:0]                in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [crc15_pkg::REM_W-1:0] out_rem,
  output logic                        out_nz,
  output logic                        out_cnt_err,
  output logic                        dp_rst,
  output logic                        dp_shift,
  output logic [N-1:0]                dp_data,
  input  logic [CNT_W-1:0]            dp_count,
  input  logic [crc15_pkg::REM_W-1:0] dp_rem
);
  import crc15_pkg::*;

  localparam int              TOTAL = total_shifts(N, R);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  if (TOTAL > (2 ** CNT_W) - 1) begin : g_width_check
    $error("crc15_seq_ctrl: N+R does not fit the shift counter");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     data_q, data_d;
  logic             clr_q, clr_d;
  logic             in_ready_q, in_ready_d;
  logic             shift_q, shift_d;
  logic             valid_q, valid_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    clr_d      = clr_q;
    in_ready_d = in_ready_q;
    shift_d    = shift_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid) begin
          data_d     = in_data;
          clr_d      = 1'b1;
          in_ready_d = 1'b0;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        clr_d   = 1'b0;
        cnt_d   = '0;
        shift_d = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          shift_d = 1'b0;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_d    = 1'b0;
          in_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      clr_q      <= 1'b0;
      in_ready_q <= 1'b1;
      shift_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      clr_q      <= clr_d;
      in_ready_q <= in_ready_d;
      shift_q    <= shift_d;
      valid_q    <= valid_d;
    end
  end

  // The register is frozen in DONE, so its outputs are stable for the whole result phase.
  assign dp_rst      = rst | clr_q;
  assign dp_shift    = shift_q;
  assign dp_data     = data_q;
  assign in_ready    = in_ready_q;
  assign out_valid   = valid_q;
  assign out_rem     = valid_q ? dp_rem : '0;
  assign out_nz      = valid_q & (|dp_rem);
  assign out_cnt_err = valid_q & (dp_count != CNT_W'(TOTAL));

endmodule
`default_nettype wire

// File: tb/tb_crc15_seq_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_crc15_seq_ctrl : directed + random words against a closed-form
// remainder reference, two controller instances (R=15 and R=0). Rev 1.0
// ------------------------------------------------------------------
module tb_crc15_seq_ctrl;
  localparam int N  = 64;
  localparam int R  = 15;
  localparam int CW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_cmp = 0;
  int n_mis = 0;

  // main instance (R=15)
  logic          in_valid, in_ready, out_valid, out_ready, out_nz, out_cnt_err;
  logic          dp_rst, dp_shift, force_cnt;
  logic [N-1:0]  in_data, dp_data, m_aligned;
  logic [14:0]   out_rem, dp_rem, m_rem;
  logic [CW-1:0] dp_count, m_cnt;

  crc15_seq_ctrl #(.N(N), .R(R), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_rem(out_rem),
    .out_nz(out_nz), .out_cnt_err(out_cnt_err),
    .dp_rst(dp_rst), .dp_shift(dp_shift), .dp_data(dp_data),
    .dp_count(dp_count), .dp_rem(dp_rem)
  );

  // Remainder register seen by the controller; count can be stuck to inject a fault.
  assign m_aligned = dp_data << m_cnt;
  assign dp_rem    = m_rem;
  assign dp_count  = force_cnt ? CW'(40) : m_cnt;
  always @(posedge clk or posedge dp_rst)
    if (dp_rst) begin
      m_cnt <= '0;
      m_rem <= '0;
    end else if (dp_shift) begin
      m_cnt <= m_cnt + 1'b1;
      m_rem <= {m_aligned[N-1] ^ m_rem[0], m_rem[14:1]};
    end

  // second instance (R=0)
  logic          in_valid0, in_ready0, out_valid0, out_ready0, out_nz0, out_cnt_err0;
  logic          dp_rst0, dp_shift0;
  logic [N-1:0]  in_data0, dp_data0, m_aligned0;
  logic [14:0]   out_rem0, m_rem0;
  logic [CW-1:0] m_cnt0;

  crc15_seq_ctrl #(.N(N), .R(0), .CNT_W(CW)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_rem(out_rem0),
    .out_nz(out_nz0), .out_cnt_err(out_cnt_err0),
    .dp_rst(dp_rst0), .dp_shift(dp_shift0), .dp_data(dp_data0),
    .dp_count(m_cnt0), .dp_rem(m_rem0)
  );

  assign m_aligned0 = dp_data0 << m_cnt0;
  always @(posedge clk or posedge dp_rst0)
    if (dp_rst0) begin
      m_cnt0 <= '0;
      m_rem0 <= '0;
    end else if (dp_shift0) begin
      m_cnt0 <= m_cnt0 + 1'b1;
      m_rem0 <= {m_aligned0[N-1] ^ m_rem0[0], m_rem0[14:1]};
    end

  // A bit entering at step k lands in bit 14 and then rotates right once per
  // remaining step, so its final position follows from (L-1-k) mod 15.
  function automatic logic [14:0] ref_rem(input logic [N-1:0] d, input int r);
    int total;
    logic [14:0] res;
    total = N + r;
    res   = '0;
    for (int k = 0; k < N; k++)
      if (d[N-1-k]) res ^= 15'(1) << (14 - ((total - 1 - k) % 15));
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Caller has raised in_valid at a negedge with in_ready high.
  task automatic wait_out(output int lat, output int shifts);
    lat = -1;
    shifts = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (dp_shift) shifts++;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic wait_out0(output int lat);
    lat = -1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 1) in_valid0 = 1'b0;
      if (out_valid0) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic finish_out();
    @(negedge clk);
    chk("post_valid", 64'(out_valid), 64'd0);
    chk("post_in_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic send_word(input logic [N-1:0] d, input string tag);
    int lat, sh;
    logic [14:0] e;
    e = ref_rem(d, R);
    in_data  = d;
    in_valid = 1'b1;
    wait_out(lat, sh);
    chk({tag, "_lat"}, 64'(lat), 64'd81);
    chk({tag, "_shifts"}, 64'(sh), 64'd79);
    chk({tag, "_rem"}, 64'(out_rem), 64'(e));
    chk({tag, "_nz"}, 64'(out_nz), 64'(e != 15'd0));
    chk({tag, "_cnt_err"}, 64'(out_cnt_err), 64'd0);
    finish_out();
  endtask

  initial begin
    int lat, sh, cnt, t0, t1;
    bit got_a;
    logic [N-1:0] w, w2, a, b;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0; force_cnt = 1'b0;
    in_valid0 = 1'b0; out_ready0 = 1'b1; in_data0 = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dp_shift", 64'(dp_shift), 64'd0);
    chk("rst_dp_rst", 64'(dp_rst), 64'd1);
    chk("rst_dp_data", 64'(dp_data), 64'd0);
    chk("rst_out_rem", 64'(out_rem), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_dp_rst", 64'(dp_rst), 64'd0);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_in_ready0", 64'(in_ready0), 64'd1);

    send_word('0, "zero");
    send_word(64'h1, "lsb");
    chk("lsb_ref", 64'(ref_rem(64'h1, R)), 64'h4000);
    for (int i = 0; i < 4; i++) send_word({$urandom, $urandom}, "rand");

    // back-pressure: result held while a new word waits
    out_ready = 1'b0;
    w  = {$urandom, $urandom};
    w2 = {$urandom, $urandom};
    in_data = w; in_valid = 1'b1;
    wait_out(lat, sh);
    chk("bp_lat", 64'(lat), 64'd81);
    chk("bp_rem", 64'(out_rem), 64'(ref_rem(w, R)));
    in_data = w2; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_rem", 64'(out_rem), 64'(ref_rem(w, R)));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_dp_shift", 64'(dp_shift), 64'd0);
    end
    out_ready = 1'b1;
    finish_out();
    wait_out(lat, sh);
    chk("bp2_lat", 64'(lat), 64'd81);
    chk("bp2_rem", 64'(out_rem), 64'(ref_rem(w2, R)));
    finish_out();

    // stuck datapath count
    force_cnt = 1'b1;
    w = {$urandom, $urandom};
    in_data = w; in_valid = 1'b1;
    wait_out(lat, sh);
    chk("cf_err", 64'(out_cnt_err), 64'd1);
    chk("cf_rem", 64'(out_rem), 64'(ref_rem(w, R)));
    @(negedge clk);
    chk("cf_err_cleared", 64'(out_cnt_err), 64'd0);
    chk("cf_valid", 64'(out_valid), 64'd0);
    force_cnt = 1'b0;

    // reset during the 30th shift cycle
    in_data = {$urandom, $urandom}; in_valid = 1'b1;
    cnt = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
      if (dp_shift) cnt++;
      if (cnt == 30) break;
    end
    chk("mr_reached", 64'(cnt), 64'd30);
    rst = 1'b1;
    #1;
    chk("mr_dp_rst", 64'(dp_rst), 64'd1);
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_dp_shift", 64'(dp_shift), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_in_ready", 64'(in_ready), 64'd1);
    chk("mr_idle_shift", 64'(dp_shift), 64'd0);
    send_word({$urandom, $urandom}, "after_rst");

    // back-to-back with in_valid and out_ready held high
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    in_data = a; in_valid = 1'b1;
    t0 = -1; t1 = -1; got_a = 1'b0;
    for (int c = 0; c < 250; c++) begin
      if (in_ready && in_valid) begin
        if (t0 < 0) t0 = c;
        else begin
          t1 = c;
          break;
        end
      end
      if (out_valid && !got_a) begin
        got_a = 1'b1;
        chk("b2b_rem_a", 64'(out_rem), 64'(ref_rem(a, R)));
      end
      @(negedge clk);
      if (c == t0) in_data = b;
    end
    chk("b2b_got_a", 64'(got_a), 64'd1);
    chk("b2b_period", 64'(t1 - t0), 64'd82);
    wait_out(lat, sh);
    chk("b2b_lat_b", 64'(lat), 64'd81);
    chk("b2b_rem_b", 64'(out_rem), 64'(ref_rem(b, R)));
    finish_out();

    // R=0 instance
    in_data0 = 64'h1; in_valid0 = 1'b1;
    wait_out0(lat);
    chk("r0_lat", 64'(lat), 64'd66);
    chk("r0_rem", 64'(out_rem0), 64'h4000);
    chk("r0_nz", 64'(out_nz0), 64'd1);
    chk("r0_cnt_err", 64'(out_cnt_err0), 64'd0);
    @(negedge clk);
    chk("r0_post_valid", 64'(out_valid0), 64'd0);
    w = {$urandom, $urandom};
    in_data0 = w; in_valid0 = 1'b1;
    wait_out0(lat);
    chk("r0_rand_lat", 64'(lat), 64'd66);
    chk("r0_rand_rem", 64'(out_rem0), 64'(ref_rem(w, 0)));
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
`default_nettype wire
